// File: rtl/sram_controller_pkg.sv
// Shared widths, the data-memory base address and FSM state encoding for the SRAM controller.
package sram_controller_pkg;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned SRAM_ADDR_WIDTH = 18;
  localparam int unsigned HALF_WIDTH      = 16;
  localparam int unsigned DMEM_BASE       = 1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

  // Byte address to SRAM word index; addresses below the base wrap silently.
  function automatic logic [SRAM_ADDR_WIDTH-2:0] sram_word(input logic [WORD_WIDTH-1:0] addr,
                                                           input logic [WORD_WIDTH-1:0] base);
    return (SRAM_ADDR_WIDTH-1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus between the pipeline (master) and the SRAM controller (slave).
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [WORD_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Phase counter: counts 0..Cycles-1 while enabled, flags the final cycle of a phase.
module sram_controller_wait_counter #(
  parameter int unsigned Cycles = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic last_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CntW'(Cycles - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage responder: splits each 32-bit word access into two halfword phases on an async SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DMEM_BASE,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_controller_if.slave           mem,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [HALF_WIDTH-1:0]      sram_dq,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  state_e                     state_q, state_d;
  logic [SRAM_ADDR_WIDTH-2:0] word_q, word_d;
  logic [WORD_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       write_q, write_d;
  logic [WORD_WIDTH-1:0]      rdata_q, rdata_d;

  logic                  req;
  logic                  busy;
  logic                  last;
  logic                  dq_oe;
  logic [HALF_WIDTH-1:0] dq_out;

  assign req  = mem.mem_read | mem.mem_write;
  assign busy = (state_q == StLo) || (state_q == StHi);

  // Clearing outside LO/HI guarantees every phase starts from zero.
  sram_controller_wait_counter #(
    .Cycles (WAIT_CYCLES)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (!busy || last),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLo;
          word_d  = sram_word(mem.addr, WORD_WIDTH'(ADDR_BASE));
          wdata_d = mem.wdata;
          write_d = mem.mem_write;
        end
      end
      StLo: begin
        if (last) begin
          state_d = StHi;
          if (!write_q) rdata_d[HALF_WIDTH-1:0] = sram_dq;
        end
      end
      StHi: begin
        if (last) begin
          state_d = StDone;
          if (!write_q) rdata_d[WORD_WIDTH-1:HALF_WIDTH] = sram_dq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // we_n rises in the last cycle of a phase so data is held past the strobe.
  always_comb begin
    sram_addr = busy ? {word_q, state_q == StHi} : '0;
    sram_we_n = !(busy && write_q && !last);
    sram_oe_n = !(busy && !write_q);
    dq_oe     = busy && write_q;
    dq_out    = (state_q == StHi) ? wdata_q[WORD_WIDTH-1:HALF_WIDTH] : wdata_q[HALF_WIDTH-1:0];
  end

  assign sram_dq   = dq_oe ? dq_out : {HALF_WIDTH{1'bz}};
  assign mem.rdata = rdata_q;
  assign mem.ready = ((state_q == StIdle) && !req) || (state_q == StDone);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a 2^18 x 16 async SRAM model and a word-level reference.
module tb_sram_controller;

  logic        clk;
  logic        rst_n;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;

  sram_controller_if bus ();

  sram_controller dut (
    .clk       (clk),
    .rst       (rst_n),
    .mem       (bus),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board SRAM model
  logic [15:0] sram [0:262143];
  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq;

  // Word-level reference
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  typedef struct {
    bit          is_write;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: times each transaction and checks its completion against the queue head.
  bit in_txn = 0;
  int cyc, we_lo, oe_lo;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_txn = 0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (!in_txn) begin
        in_txn = 1; cyc = 0; we_lo = 0; oe_lo = 0;
      end else begin
        cyc++;
      end
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (bus.ready) begin
        in_txn = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", bus.rdata, e.rdata);
          chk("latency", 32'(cyc), 32'd5);
          chk("we_n_low_cycles", 32'(we_lo), e.is_write ? 32'd2 : 32'd0);
          chk("oe_n_low_cycles", 32'(oe_lo), e.is_write ? 32'd0 : 32'd4);
        end
      end
    end
  end

  // Caller is just after a posedge; returns just after the posedge that ends DONE, request held.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble);
    exp_t e;
    int   w;
    bit   done;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    w = word_of(a);
    e.is_write = wr;
    if (wr) begin
      ref_mem[w] = d;
    end else begin
      last_rd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
    done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1;
        break;
      end
      if (scramble && n == 2) begin
        bus.addr  = $urandom;
        bus.wdata = $urandom;
      end
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    time t0;
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
    last_rd       = 32'h0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    rst_n         = 1'b0;
    #12;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 1, 32'd1028, 32'hDEADBEEF, 0);
    go_idle();
    chk("sram2", {16'd0, sram[2]}, 32'h0000BEEF);
    chk("sram3", {16'd0, sram[3]}, 32'h0000DEAD);
    issue(1, 0, 32'd1028, 32'h0, 0);
    go_idle();

    t0 = $time;
    issue(0, 1, 32'd1024, 32'h11112222, 0);
    issue(1, 0, 32'd1024, 32'h0, 0);
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd12);
    go_idle();

    issue(1, 1, 32'd1032, 32'h0000FFFF, 0);
    go_idle();
    chk("sram4", {16'd0, sram[4]}, 32'h0000FFFF);
    chk("sram5", {16'd0, sram[5]}, 32'h00000000);

    // Reset during cycle 2 of a write to a word never read back.
    bus.mem_write = 1'b1;
    bus.addr      = 32'd1424;
    bus.wdata     = $urandom;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    bus.mem_write = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("abort_ready", {31'd0, bus.ready}, 32'd1);
    chk("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 0, 32'd1024, 32'h0, 0);
    go_idle();

    for (int i = 0; i < 4; i++) begin
      bus.addr  = $urandom;
      bus.wdata = $urandom;
      @(negedge clk);
      chk("idle_ready", {31'd0, bus.ready}, 32'd1);
      chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("idle_sram_addr", {14'd0, sram_addr}, 32'd0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 40; i++) begin
      int          k;
      int unsigned op;
      logic [31:0] a;
      k  = int'($urandom_range(67)) - 4;
      a  = 32'd1024 + 32'(k * 4);
      op = $urandom_range(2);
      issue(op != 1, op != 0, a, $urandom, $urandom_range(1) == 1);
      if ($urandom_range(1) == 1) go_idle();
    end
    go_idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
